// File: rtl/dma_pkg.sv
// Shared definitions for the DMA channel arbiter: channel limits, arbiter
// state encoding and the CH_CTRL priority-field extractor.
package dma_pkg;

  localparam int MAX_CH     = 16;
  localparam int PRIO_W_DEF = 4;
  localparam int MAX_PRIO_W = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  typedef logic [MAX_PRIO_W-1:0]        prio_t;
  typedef logic [MAX_CH*MAX_PRIO_W-1:0] prio_bus_t;

  // Priority of channel ch from a packed bus of prio_w-bit fields, zero-extended.
  function automatic prio_t ch_prio_field(input prio_bus_t bus, input int unsigned ch,
                                          input int unsigned prio_w);
    prio_t mask;
    mask = (prio_t'(1) << prio_w) - prio_t'(1);
    return prio_t'(bus >> (ch * prio_w)) & mask;
  endfunction

endpackage

// File: rtl/dma_prio_rr_pick.sv
// Combinational winner selection: highest priority among eligible requesters,
// ties broken by the first one found scanning upward from rr_ptr+1.
module dma_prio_rr_pick
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PRIO_W = PRIO_W_DEF,
  parameter int ID_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH*PRIO_W-1:0] prio_i,
  input  logic [ID_W-1:0]          rr_ptr_i,
  input  logic [NUM_CH-1:0]        excl_i,
  output logic [NUM_CH-1:0]        win_oh_o,
  output logic [ID_W-1:0]          win_id_o,
  output logic                     any_valid_o
);

  prio_t             prio_arr [NUM_CH];
  logic [NUM_CH-1:0] elig;
  prio_t             max_p;
  logic [ID_W-1:0]   idx;
  logic              found;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_prio
      assign prio_arr[gi] = ch_prio_field(prio_bus_t'(prio_i), gi, PRIO_W);
    end
  endgenerate

  assign elig        = req_i & ~excl_i;
  assign any_valid_o = |elig;

  always_comb begin
    max_p    = '0;
    idx      = '0;
    found    = 1'b0;
    win_oh_o = '0;
    win_id_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ID_W'(i);
      if (elig[idx] && (prio_arr[idx] > max_p)) max_p = prio_arr[idx];
    end
    // First eligible channel at the top priority level, in round-robin order.
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = ID_W'((int'(rr_ptr_i) + k) % NUM_CH);
      if (!found && elig[idx] && (prio_arr[idx] == max_p)) begin
        found          = 1'b1;
        win_oh_o[idx]  = 1'b1;
        win_id_o       = idx;
      end
    end
  end

endmodule

// File: rtl/dma_chn_arbiter.sv
// Grants the shared AXI data-path engine to one DMA channel per tenure,
// with priority + round-robin selection and beat-count driven yield requests.
module dma_chn_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int PRIO_W    = PRIO_W_DEF,
  parameter int MAX_BEATS = 16,
  parameter int ID_W      = $clog2(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_CH-1:0]        ch_req_i,
  input  logic [NUM_CH*PRIO_W-1:0] ch_prio_i,
  input  logic                     beat_valid_i,
  input  logic                     burst_done_i,
  output logic [NUM_CH-1:0]        gnt_o,
  output logic [ID_W-1:0]          gnt_id_o,
  output logic                     gnt_valid_o,
  output logic                     yield_req_o,
  output logic [7:0]               beat_cnt_o
);

  localparam logic [7:0] MAX_BEATS_B = 8'(MAX_BEATS);

  arb_state_e        state_q, state_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              yield_q, yield_d;

  prio_t             prio_arr [NUM_CH];
  logic [NUM_CH-1:0] comp_vec;
  logic              owner_req;
  logic              tenure_end;
  logic [NUM_CH-1:0] excl;
  logic [ID_W-1:0]   pick_ptr;
  logic [NUM_CH-1:0] pick_oh;
  logic [ID_W-1:0]   pick_id;
  logic              pick_any;

  // Other requesters at or above the owner's current priority can force a yield.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_comp
      assign prio_arr[gi] = ch_prio_field(prio_bus_t'(ch_prio_i), gi, PRIO_W);
      assign comp_vec[gi] = ch_req_i[gi] && !gnt_q[gi] && (prio_arr[gi] >= prio_arr[gnt_id_q]);
    end
  endgenerate

  assign owner_req  = |(ch_req_i & gnt_q);
  assign tenure_end = (state_q == ARB_OWN) && (burst_done_i || !owner_req);
  assign excl       = (tenure_end && !owner_req) ? gnt_q : '0;
  // At a tenure end the pointer moves to the owner in the same cycle as the pick.
  assign pick_ptr   = (state_q == ARB_OWN) ? gnt_id_q : rr_ptr_q;

  dma_prio_rr_pick #(
    .NUM_CH (NUM_CH),
    .PRIO_W (PRIO_W),
    .ID_W   (ID_W)
  ) u_pick (
    .req_i       (ch_req_i),
    .prio_i      (ch_prio_i),
    .rr_ptr_i    (pick_ptr),
    .excl_i      (excl),
    .win_oh_o    (pick_oh),
    .win_id_o    (pick_id),
    .any_valid_o (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    yield_d    = yield_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d    = ARB_OWN;
          gnt_d      = pick_oh;
          gnt_id_d   = pick_id;
          beat_cnt_d = '0;
          yield_d    = 1'b0;
        end
      end
      ARB_OWN: begin
        if (tenure_end) begin
          rr_ptr_d   = gnt_id_q;
          beat_cnt_d = '0;
          yield_d    = 1'b0;
          if (pick_any) begin
            gnt_d    = pick_oh;
            gnt_id_d = pick_id;
          end else begin
            state_d  = ARB_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
          end
        end else begin
          if (beat_valid_i && (beat_cnt_q != 8'hFF)) beat_cnt_d = beat_cnt_q + 8'd1;
          if ((beat_cnt_q >= MAX_BEATS_B) && (|comp_vec)) yield_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      rr_ptr_q   <= ID_W'(NUM_CH - 1);
      beat_cnt_q <= '0;
      yield_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      yield_q    <= yield_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = gnt_id_q;
  assign gnt_valid_o = |gnt_q;
  assign yield_req_o = yield_q;
  assign beat_cnt_o  = beat_cnt_q;

endmodule

// File: tb/tb_dma_chn_arbiter.sv
// Self-checking bench for dma_chn_arbiter: directed vector table, multi-cycle
// corner sequences and randomized traffic against a behavioural tenure model.
module tb_dma_chn_arbiter;

  localparam int N  = 4;
  localparam int PW = 4;
  localparam int MB = 16;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  ch_req;
  logic [N*PW-1:0] ch_prio;
  logic          beat_valid;
  logic          burst_done;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          gnt_valid;
  logic          yield_req;
  logic [7:0]    beat_cnt;

  always #5 clk = ~clk;

  dma_chn_arbiter #(
    .NUM_CH    (N),
    .PRIO_W    (PW),
    .MAX_BEATS (MB),
    .ID_W      (IW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .ch_req_i     (ch_req),
    .ch_prio_i    (ch_prio),
    .beat_valid_i (beat_valid),
    .burst_done_i (burst_done),
    .gnt_o        (gnt),
    .gnt_id_o     (gnt_id),
    .gnt_valid_o  (gnt_valid),
    .yield_req_o  (yield_req),
    .beat_cnt_o   (beat_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: who owns the engine, where round-robin resumes, beats, yield.
  int m_owner = -1;
  int m_rr    = N - 1;
  int m_cnt   = 0;
  bit m_yld   = 1'b0;

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [15:0]  prio;
    logic         beat;
    logic         done;
    logic [N-1:0] exp_gnt;
    logic         exp_yld;
    logic [7:0]   exp_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int prio_of(input logic [N*PW-1:0] prio, input int ch);
    logic [PW-1:0] f;
    f = prio[ch*PW +: PW];
    return int'(f);
  endfunction

  // Walk channels in round-robin order after 'after'; keep the first strictly-best priority.
  function automatic int pick(input logic [N-1:0] req, input logic [N*PW-1:0] prio,
                              input int after, input int excl);
    int best;
    int bestp;
    int i;
    best  = -1;
    bestp = -1;
    for (int k = 1; k <= N; k++) begin
      i = (after + k) % N;
      if (req[i] && (i != excl) && (prio_of(prio, i) > bestp)) begin
        best  = i;
        bestp = prio_of(prio, i);
      end
    end
    return best;
  endfunction

  task automatic model_step();
    int  w;
    bit  dropped;
    bit  comp;
    if (reset) begin
      m_owner = -1; m_rr = N - 1; m_cnt = 0; m_yld = 1'b0;
    end else if (m_owner < 0) begin
      w = pick(ch_req, ch_prio, m_rr, -1);
      if (w >= 0) begin
        m_owner = w; m_cnt = 0; m_yld = 1'b0;
      end
    end else begin
      dropped = !ch_req[m_owner];
      if (burst_done || dropped) begin
        m_rr    = m_owner;
        m_owner = pick(ch_req, ch_prio, m_rr, dropped ? m_rr : -1);
        m_cnt   = 0;
        m_yld   = 1'b0;
      end else begin
        comp = 1'b0;
        for (int j = 0; j < N; j++)
          if (j != m_owner && ch_req[j] && prio_of(ch_prio, j) >= prio_of(ch_prio, m_owner))
            comp = 1'b1;
        if (m_cnt >= MB && comp) m_yld = 1'b1;
        if (beat_valid && m_cnt < 255) m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("model_gnt", int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
    check("model_gnt_valid", int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
    if (m_owner >= 0) check("model_gnt_id", int'(gnt_id), m_owner);
    check("model_yield", int'(yield_req), int'(m_yld));
    check("model_beat_cnt", int'(beat_cnt), m_cnt);
  endtask

  task automatic drive(input logic rst, input logic [N-1:0] req, input logic [15:0] prio,
                       input logic beat, input logic done);
    reset      = rst;
    ch_req     = req;
    ch_prio    = prio;
    beat_valid = beat;
    burst_done = done;
  endtask

  task automatic add(input logic rst, input logic [N-1:0] req, input logic [15:0] prio,
                     input logic beat, input logic done, input logic [N-1:0] eg,
                     input logic ey, input logic [7:0] ec);
    vec_t v;
    v.rst = rst; v.req = req; v.prio = prio; v.beat = beat; v.done = done;
    v.exp_gnt = eg; v.exp_yld = ey; v.exp_cnt = ec;
    tbl.push_back(v);
  endtask

  initial begin
    int eid;
    logic [N-1:0] flip;

    drive(1'b1, '0, 16'h0000, 1'b0, 1'b0);

    // rst req prio beat done | gnt yld cnt
    add(1, 4'b0000, 16'h0000, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b0100, 16'h0000, 0, 0, 4'b0100, 0, 0);
    add(0, 4'b0100, 16'h0000, 1, 0, 4'b0100, 0, 1);
    add(0, 4'b0100, 16'h0000, 1, 0, 4'b0100, 0, 2);
    add(0, 4'b0100, 16'h0000, 1, 1, 4'b0100, 0, 0);
    add(0, 4'b0000, 16'h0000, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b1010, 16'h7030, 0, 0, 4'b1000, 0, 0);
    add(0, 4'b1010, 16'h7030, 1, 0, 4'b1000, 0, 1);
    add(0, 4'b1010, 16'h7030, 0, 1, 4'b1000, 0, 0);
    add(0, 4'b0000, 16'h7030, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 16'h5555, 0, 0, 4'b0001, 0, 0);
    add(0, 4'b1111, 16'h5555, 0, 1, 4'b0010, 0, 0);
    add(0, 4'b1111, 16'h5555, 0, 1, 4'b0100, 0, 0);
    add(0, 4'b1111, 16'h5555, 0, 1, 4'b1000, 0, 0);
    add(0, 4'b1111, 16'h5555, 0, 1, 4'b0001, 0, 0);
    add(0, 4'b0000, 16'h5555, 0, 0, 4'b0000, 0, 0);

    foreach (tbl[v]) begin
      drive(tbl[v].rst, tbl[v].req, tbl[v].prio, tbl[v].beat, tbl[v].done);
      step();
      check("tbl_gnt", int'(gnt), int'(tbl[v].exp_gnt));
      check("tbl_gnt_valid", int'(gnt_valid), int'(|tbl[v].exp_gnt));
      if (|tbl[v].exp_gnt) begin
        eid = 0;
        for (int b = 0; b < N; b++) if (tbl[v].exp_gnt[b]) eid = b;
        check("tbl_gnt_id", int'(gnt_id), eid);
      end
      check("tbl_yield", int'(yield_req), int'(tbl[v].exp_yld));
      check("tbl_beat_cnt", int'(beat_cnt), int'(tbl[v].exp_cnt));
      $display("[TB] vec %0d req=%b prio=%h beat=%0b done=%0b -> gnt=%b cnt=%0d yld=%0b",
               v, tbl[v].req, tbl[v].prio, tbl[v].beat, tbl[v].done, gnt, beat_cnt, yield_req);
    end

    // Yield against an equal-priority competitor, then handoff with no idle cycle.
    drive(1, 4'b0000, 16'h0404, 0, 0); step();
    drive(0, 4'b0001, 16'h0404, 0, 0); step();
    drive(0, 4'b0101, 16'h0404, 1, 0); repeat (MB) step();
    check("yield_before_eval", int'(yield_req), 0);
    drive(0, 4'b0101, 16'h0404, 0, 0); step();
    check("yield_set", int'(yield_req), 1);
    drive(0, 4'b0101, 16'h0404, 0, 1); step();
    check("yield_handoff_gnt", int'(gnt), 4'b0100);
    check("yield_handoff_cnt", int'(beat_cnt), 0);
    $display("[TB] seq yield-equal: gnt=%b yld=%0b", gnt, yield_req);

    // Lower-priority competitor never causes a yield.
    drive(1, 4'b0000, 16'h0204, 0, 0); step();
    drive(0, 4'b0001, 16'h0204, 0, 0); step();
    drive(0, 4'b0101, 16'h0204, 1, 0); repeat (MB + 4) step();
    drive(0, 4'b0101, 16'h0204, 0, 0); step();
    check("yield_lowprio", int'(yield_req), 0);
    drive(0, 4'b0101, 16'h0204, 0, 1); step();
    check("lowprio_regrant", int'(gnt), 4'b0001);
    $display("[TB] seq yield-lower: gnt=%b yld=%0b", gnt, yield_req);

    // Abort, then simultaneous drop + burst_done.
    drive(1, 4'b0000, 16'h0000, 0, 0); step();
    drive(0, 4'b0010, 16'h0000, 0, 0); step();
    drive(0, 4'b1010, 16'h0000, 1, 0); repeat (3) step();
    drive(0, 4'b1000, 16'h0000, 0, 0); step();
    check("abort_gnt", int'(gnt), 4'b1000);
    drive(0, 4'b1010, 16'h0000, 0, 1); step();
    check("abort_rr_gnt", int'(gnt), 4'b0010);
    drive(0, 4'b1000, 16'h0000, 0, 1); step();
    check("drop_done_gnt", int'(gnt), 4'b1000);
    drive(0, 4'b1000, 16'h0000, 0, 0); step();
    check("drop_done_hold", int'(gnt), 4'b1000);
    $display("[TB] seq abort: gnt=%b", gnt);

    // Reset mid-tenure, then equal-priority tie goes to channel 0.
    drive(1, 4'b0000, 16'h0000, 0, 0); step();
    drive(0, 4'b0100, 16'h0000, 0, 0); step();
    drive(0, 4'b0100, 16'h0000, 1, 0); repeat (9) step();
    check("pre_reset_cnt", int'(beat_cnt), 9);
    drive(1, 4'b0100, 16'h0000, 1, 0); step();
    check("reset_gnt", int'(gnt), 0);
    check("reset_cnt", int'(beat_cnt), 0);
    check("reset_yield", int'(yield_req), 0);
    drive(0, 4'b1111, 16'h3333, 0, 0); step();
    check("post_reset_gnt", int'(gnt), 4'b0001);
    $display("[TB] seq reset-mid: gnt=%b", gnt);

    // Beat counter saturates at 255.
    drive(0, 4'b0001, 16'h3333, 1, 0); repeat (260) step();
    check("beat_sat", int'(beat_cnt), 255);
    $display("[TB] seq saturate: cnt=%0d", beat_cnt);

    // Randomized traffic checked against the model every cycle.
    drive(1, 4'b0000, 16'h0000, 0, 0); step();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      flip = '0;
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 99) < 20);
      ch_req     = ch_req ^ flip;
      if (c % 50 == 0) ch_prio = 16'($urandom) & 16'h3333;
      beat_valid = $urandom_range(0, 1) == 1;
      burst_done = $urandom_range(0, 99) < 5;
      reset      = $urandom_range(0, 299) == 0;
      step();
      if (c % 500 == 499)
        $display("[TB] random cycle %0d: gnt=%b cnt=%0d yld=%0b", c + 1, gnt, beat_cnt, yield_req);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
